sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter_pkg.sv | 16 +
 rtl/sram_port_arbiter_if.sv | 39 +++
 rtl/sram_port_arbiter.sv | 67 ++++++
 tb/tb_sram_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and default sizes for the image-SRAM port arbiter.
// Defaults match the image SRAM instance (8-bit words, 64K deep).
package sram_port_arbiter_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH   = 16;
    localparam int DEF_STARVE_LIMIT = 4;

    // Owner of the SRAM read data returning in the next cycle
    typedef enum logic [1:0] {
        RSEL_NONE = 2'd0,
        RSEL_A    = 2'd1,
        RSEL_B    = 2'd2
    } rsel_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Request/grant/return bundle for both requesters plus the SRAM pins.
// master = requesters and SRAM side, slave = arbiter.
interface sram_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  a_req;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  a_gnt;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport master (
        output a_req, a_addr, b_req, b_we, b_addr, b_wdata, ram_rdata,
        input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, ram_rdata,
        output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-port sync SRAM between video fetch (A, priority) and
// game logic (B, r/w); a starvation counter guarantees B progress.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input logic               clk,
    input logic               reset,
    sram_port_arbiter_if.slave bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]         wait_cnt;
    rsel_e                 rsel;
    logic                  force_b;
    logic                  a_gnt;
    logic                  b_gnt;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [DATA_WIDTH-1:0] rdata;

    // Grants are suppressed during reset so the SRAM sees no access.
    always_comb begin
        force_b  = (wait_cnt == LIMIT);
        a_gnt    = ~reset & bus.a_req & ~(bus.b_req & force_b);
        b_gnt    = ~reset & bus.b_req & (~bus.a_req | force_b);
        addr_mux = b_gnt ? bus.b_addr : bus.a_addr;
        rdata    = bus.ram_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            rsel     <= RSEL_NONE;
        end else begin
            if (b_gnt)
                wait_cnt <= '0;
            else if (bus.b_req && wait_cnt != LIMIT)
                wait_cnt <= wait_cnt + 1'b1;

            // B writes return the write-first echo, which nobody consumes
            if (a_gnt)
                rsel <= RSEL_A;
            else if (b_gnt && !bus.b_we)
                rsel <= RSEL_B;
            else
                rsel <= RSEL_NONE;
        end
    end

    assign bus.a_gnt     = a_gnt;
    assign bus.b_gnt     = b_gnt;
    assign bus.ram_en    = a_gnt | b_gnt;
    assign bus.ram_we    = b_gnt & bus.b_we;
    assign bus.ram_addr  = addr_mux;
    assign bus.ram_wdata = bus.b_wdata;

    assign bus.a_rvalid  = (rsel == RSEL_A);
    assign bus.b_rvalid  = (rsel == RSEL_B);
    assign bus.a_rdata   = rdata;
    assign bus.b_rdata   = rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural write-first SRAM.
module tb_sram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Single-port synchronous SRAM, one-cycle latency, write-first
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                mem[bus.ram_addr] <= bus.ram_wdata;
                bus.ram_rdata     <= bus.ram_wdata;
            end else begin
                bus.ram_rdata <= mem[bus.ram_addr];
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.a_req   = 1'b0;
        bus.a_addr  = '0;
        bus.b_req   = 1'b0;
        bus.b_we    = 1'b0;
        bus.b_addr  = '0;
        bus.b_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.a_req = 1'b1;
        bus.a_addr = 16'h0010;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.a_gnt !== 1'b0 || bus.ram_en !== 1'b0) begin
                errors++;
                $display("FAIL reset_gnt: a_gnt=%b ram_en=%b required 0/0", bus.a_gnt, bus.ram_en);
            end
            next_cycle();
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.a_rvalid !== 1'b0 || bus.b_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rvalid: a_rvalid=%b b_rvalid=%b required 0/0", bus.a_rvalid, bus.b_rvalid);
        end
        checks++;
        if (dut.wait_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_wait_cnt: got %0d required 0", dut.wait_cnt);
        end
        @(negedge clk);
        checks++;
        if (bus.a_gnt !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_gnt: a_gnt=%b required 1", bus.a_gnt);
        end
        next_cycle();
        idle();
        next_cycle();
    endtask

    task automatic test_a_alone();
        mem[16'h0010] = 8'h5A;
        bus.a_req  = 1'b1;
        bus.a_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0 || bus.ram_addr !== 16'h0010) begin
            errors++;
            $display("FAIL a_alone_gnt: a_gnt=%b b_gnt=%b ram_addr=%h required 1/0/0010",
                     bus.a_gnt, bus.b_gnt, bus.ram_addr);
        end
        next_cycle();
        idle();
        checks++;
        if (bus.a_rvalid !== 1'b1 || bus.b_rvalid !== 1'b0 || bus.a_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL a_alone_data: a_rvalid=%b b_rvalid=%b a_rdata=%h required 1/0/5a",
                     bus.a_rvalid, bus.b_rvalid, bus.a_rdata);
        end
        next_cycle();
    endtask

    task automatic test_b_alone();
        mem[16'h0042] = 8'h3C;
        bus.b_req  = 1'b1;
        bus.b_addr = 16'h0042;
        @(negedge clk);
        checks++;
        if (bus.b_gnt !== 1'b1 || bus.a_gnt !== 1'b0 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL b_alone_gnt: b_gnt=%b a_gnt=%b ram_we=%b required 1/0/0",
                     bus.b_gnt, bus.a_gnt, bus.ram_we);
        end
        next_cycle();
        idle();
        checks++;
        if (bus.b_rvalid !== 1'b1 || bus.a_rvalid !== 1'b0 || bus.b_rdata !== 8'h3C
            || dut.wait_cnt !== 3'd0) begin
            errors++;
            $display("FAIL b_alone_data: b_rvalid=%b a_rvalid=%b b_rdata=%h wait_cnt=%0d required 1/0/3c/0",
                     bus.b_rvalid, bus.a_rvalid, bus.b_rdata, dut.wait_cnt);
        end
        next_cycle();
    endtask

    task automatic test_write_then_read();
        bus.b_req   = 1'b1;
        bus.b_we    = 1'b1;
        bus.b_addr  = 16'h1234;
        bus.b_wdata = 8'hC3;
        @(negedge clk);
        checks++;
        if (bus.b_gnt !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 16'h1234
            || bus.ram_wdata !== 8'hC3) begin
            errors++;
            $display("FAIL wr_gnt: b_gnt=%b ram_we=%b ram_addr=%h ram_wdata=%h required 1/1/1234/c3",
                     bus.b_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        next_cycle();
        idle();
        bus.a_req  = 1'b1;
        bus.a_addr = 16'h1234;
        checks++;
        if (bus.b_rvalid !== 1'b0 || bus.a_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_no_rvalid: b_rvalid=%b a_rvalid=%b required 0/0", bus.b_rvalid, bus.a_rvalid);
        end
        next_cycle();
        idle();
        checks++;
        if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 8'hC3) begin
            errors++;
            $display("FAIL raw_read: a_rvalid=%b a_rdata=%h required 1/c3", bus.a_rvalid, bus.a_rdata);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic exp_b;
        mem[16'h0001] = 8'h77;
        mem[16'h0002] = 8'h11;
        bus.a_req  = 1'b1;
        bus.a_addr = 16'h0002;
        bus.b_req  = 1'b1;
        bus.b_addr = 16'h0001;
        for (int k = 1; k <= 10; k++) begin
            exp_b = (k % 5 == 0);
            @(negedge clk);
            checks++;
            if (bus.a_gnt !== !exp_b || bus.b_gnt !== exp_b) begin
                errors++;
                $display("FAIL starve_gnt[%0d]: a_gnt=%b b_gnt=%b required %b/%b",
                         k, bus.a_gnt, bus.b_gnt, !exp_b, exp_b);
            end
            next_cycle();
            checks++;
            if (bus.b_rvalid !== exp_b || bus.a_rvalid !== !exp_b
                || bus.a_rdata !== (exp_b ? 8'h77 : 8'h11)) begin
                errors++;
                $display("FAIL starve_rvalid[%0d]: a_rvalid=%b b_rvalid=%b rdata=%h required %b/%b/%h",
                         k, bus.a_rvalid, bus.b_rvalid, bus.a_rdata, !exp_b, exp_b,
                         exp_b ? 8'h77 : 8'h11);
            end
        end
        idle();
        next_cycle();
    endtask

    task automatic test_mid_reset();
        bus.a_req = 1'b1;
        bus.b_req = 1'b1;
        bus.a_addr = 16'h0010;
        bus.b_addr = 16'h0001;
        next_cycle();
        idle();
        reset = 1'b1;
        bus.a_req = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.a_gnt !== 1'b0 || bus.ram_en !== 1'b0 || dut.wait_cnt !== 3'd1) begin
            errors++;
            $display("FAIL mid_reset_gnt: a_gnt=%b ram_en=%b wait_cnt=%0d required 0/0/1",
                     bus.a_gnt, bus.ram_en, dut.wait_cnt);
        end
        next_cycle();
        reset = 1'b0;
        idle();
        checks++;
        if (bus.a_rvalid !== 1'b0 || bus.b_rvalid !== 1'b0 || dut.wait_cnt !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_clear: a_rvalid=%b b_rvalid=%b wait_cnt=%0d required 0/0/0",
                     bus.a_rvalid, bus.b_rvalid, dut.wait_cnt);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        for (int i = 0; i < 8; i++) begin
            bus.a_req  = 1'b1;
            bus.a_addr = 16'(i);
            @(negedge clk);
            checks++;
            if (bus.a_gnt !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gnt[%0d]: a_gnt=%b required 1", i, bus.a_gnt);
            end
            next_cycle();
            exp = 8'h10 + 8'(i);
            checks++;
            if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== exp) begin
                errors++;
                $display("FAIL b2b_data[%0d]: a_rvalid=%b a_rdata=%h required 1/%h",
                         i, bus.a_rvalid, bus.a_rdata, exp);
            end
        end
        idle();
        next_cycle();
        checks++;
        if (bus.a_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_tail: a_rvalid=%b required 0", bus.a_rvalid);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_a_alone();
        test_b_alone();
        test_write_then_read();
        test_starvation();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
